// File: rtl/wb_dma_master_if.sv
// Wishbone master-side bus bundle for the DMA copy engine.
// Signal names keep the original port names so existing slave/arbiter wiring maps one to one.
interface wb_dma_master_if;
    logic        dma_stb_o;
    logic        dma_cyc_o;
    logic        dma_we_o;
    logic [3:0]  dma_sel_o;
    logic [31:0] dma_adr_o;
    logic [31:0] dma_dat_o;
    logic        dma_ack_i;
    logic [31:0] dma_dat_i;

    modport master (
        output dma_stb_o, dma_cyc_o, dma_we_o, dma_sel_o, dma_adr_o, dma_dat_o,
        input  dma_ack_i, dma_dat_i
    );

    modport slave (
        input  dma_stb_o, dma_cyc_o, dma_we_o, dma_sel_o, dma_adr_o, dma_dat_o,
        output dma_ack_i, dma_dat_i
    );
endinterface

// File: rtl/wb_dma_master.sv
// Word-by-word memory copy engine: reads a source word, writes it to the destination, repeats.
// Abort stops after the bus cycle in flight; every output comes straight from a register.
module wb_dma_master #(
    parameter int unsigned LEN_W = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start,
    input  logic                 abort,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_W-1:0]     len,
    wb_dma_master_if.master      bus,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [LEN_W-1:0]     xfer_cnt
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t           state;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len_r;
    logic             abort_pend;

    logic [LEN_W-1:0] cnt_next;
    logic [31:0]      src_next;
    logic [31:0]      dst_next;
    logic             stop;

    always_comb begin
        cnt_next = xfer_cnt + LEN_W'(1);
        src_next = src + 32'd4;
        dst_next = dst + 32'd4;
        stop     = abort | abort_pend;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            src           <= '0;
            dst           <= '0;
            len_r         <= '0;
            abort_pend    <= 1'b0;
            bus.dma_stb_o <= 1'b0;
            bus.dma_cyc_o <= 1'b0;
            bus.dma_we_o  <= 1'b0;
            bus.dma_sel_o <= '0;
            bus.dma_adr_o <= '0;
            bus.dma_dat_o <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            xfer_cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src        <= {src_addr[31:2], 2'b00};
                        dst        <= {dst_addr[31:2], 2'b00};
                        len_r      <= len;
                        xfer_cnt   <= '0;
                        aborted    <= 1'b0;
                        abort_pend <= 1'b0;
                        busy       <= 1'b1;
                        if (len != '0) begin
                            state         <= RD;
                            bus.dma_cyc_o <= 1'b1;
                            bus.dma_stb_o <= 1'b1;
                            bus.dma_we_o  <= 1'b0;
                            bus.dma_sel_o <= 4'hF;
                            bus.dma_adr_o <= {src_addr[31:2], 2'b00};
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (abort) abort_pend <= 1'b1;
                    if (bus.dma_ack_i) begin
                        if (stop) begin
                            // aborted read: the fetched word is dropped, no write follows
                            state         <= DONE;
                            done          <= 1'b1;
                            aborted       <= 1'b1;
                            bus.dma_cyc_o <= 1'b0;
                            bus.dma_stb_o <= 1'b0;
                            bus.dma_sel_o <= '0;
                        end else begin
                            state         <= WR;
                            bus.dma_we_o  <= 1'b1;
                            bus.dma_adr_o <= dst;
                            bus.dma_dat_o <= bus.dma_dat_i;
                        end
                    end
                end
                WR: begin
                    if (abort) abort_pend <= 1'b1;
                    if (bus.dma_ack_i) begin
                        src      <= src_next;
                        dst      <= dst_next;
                        xfer_cnt <= cnt_next;
                        if (cnt_next == len_r || stop) begin
                            // the last word completing always wins over a pending abort
                            state         <= DONE;
                            done          <= 1'b1;
                            aborted       <= (cnt_next != len_r);
                            bus.dma_cyc_o <= 1'b0;
                            bus.dma_stb_o <= 1'b0;
                            bus.dma_we_o  <= 1'b0;
                            bus.dma_sel_o <= '0;
                        end else begin
                            state         <= RD;
                            bus.dma_we_o  <= 1'b0;
                            bus.dma_adr_o <= src_next;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    abort_pend <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dma_master.sv
// Randomised bench for wb_dma_master: a word-level copy model predicts bus traffic and
// completion status into queues; a monitor pops and compares whenever the DUT acts on the bus.
module tb_wb_dma_master;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [LEN_W-1:0] xfer_cnt;

    wb_dma_master_if bus ();

    wb_dma_master #(.LEN_W(LEN_W)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .start    (start),
        .abort    (abort),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .bus      (bus.master),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memories: slave (DUT side) and model ----------------
    logic [31:0] mem [logic [31:0]];
    logic [31:0] mdl [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mdl.exists(a) ? mdl[a] : init_word(a);
    endfunction

    // ---------------- slave with configurable wait states ----------------
    int          wait_n = 0;
    int          wcnt;
    logic        s_ack;
    logic        spur = 1'b0;
    logic [31:0] s_dat = '0;

    assign bus.dma_ack_i = s_ack | spur;
    assign bus.dma_dat_i = s_dat;

    always @(posedge clk) begin
        if (rst) begin
            s_ack <= 1'b0;
            wcnt  <= 0;
        end else begin
            s_ack <= 1'b0;
            if (bus.dma_cyc_o && bus.dma_stb_o && !s_ack) begin
                if (wcnt >= wait_n) begin
                    s_ack <= 1'b1;
                    wcnt  <= 0;
                    if (bus.dma_we_o) mem[bus.dma_adr_o] = bus.dma_dat_o;
                    else              s_dat <= mem_rd(bus.dma_adr_o);
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    // ---------------- scoreboard queues ----------------
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } txn_t;

    typedef struct {
        int   cnt;
        logic ab;
    } fin_t;

    txn_t exp_bus  [$];
    fin_t exp_done [$];

    // ---------------- monitor ----------------
    int          acks = 0;
    logic        prev_done = 1'b0;
    logic        prev_stall = 1'b0;
    logic        st_we;
    logic [31:0] st_adr;
    logic [31:0] st_dat;

    always @(negedge clk) begin
        if (rst) begin
            prev_done  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (bus.dma_cyc_o && bus.dma_stb_o && bus.dma_ack_i) begin
                acks++;
                if (exp_bus.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL bus_unexpected: got adr %0h we %0b expected no cycle",
                             bus.dma_adr_o, bus.dma_we_o);
                end else begin
                    txn_t e;
                    e = exp_bus.pop_front();
                    check("bus_we",  {63'd0, bus.dma_we_o}, {63'd0, e.we});
                    check("bus_adr", {32'd0, bus.dma_adr_o}, {32'd0, e.adr});
                    check("bus_sel", {60'd0, bus.dma_sel_o}, 64'hF);
                    if (e.we) check("bus_wdat", {32'd0, bus.dma_dat_o}, {32'd0, e.dat});
                end
            end
            if (bus.dma_cyc_o && bus.dma_stb_o && !bus.dma_ack_i) begin
                if (prev_stall)
                    check("stall_stable", {bus.dma_we_o, bus.dma_adr_o, bus.dma_dat_o[30:0]},
                          {st_we, st_adr, st_dat[30:0]});
                prev_stall = 1'b1;
                st_we      = bus.dma_we_o;
                st_adr     = bus.dma_adr_o;
                st_dat     = bus.dma_dat_o;
            end else begin
                prev_stall = 1'b0;
            end
            if (done) begin
                check("done_single", {63'd0, prev_done}, 64'd0);
                check("busy_at_done", {63'd0, busy}, 64'd1);
                if (exp_done.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL done_unexpected: got done=1 expected none");
                end else begin
                    fin_t f;
                    f = exp_done.pop_front();
                    check("xfer_cnt", {48'd0, xfer_cnt}, 64'(f.cnt));
                    check("aborted",  {63'd0, aborted},  {63'd0, f.ab});
                end
            end
            prev_done = done;
        end
    end

    // ---------------- reference model + stimulus ----------------
    // ab_phase: index into the R0 W0 R1 W1 ... cycle sequence during which abort is pulsed, -1 none
    task automatic run(input logic [31:0] s, input logic [31:0] d, input int n, input int w,
                       input int ab_phase, input bit poke_done);
        logic [31:0] sa;
        logic [31:0] da;
        int          reads;
        int          writes;
        logic        eab;
        int          acks0;
        int          lat;
        bit          got;
        sa     = {s[31:2], 2'b00};
        da     = {d[31:2], 2'b00};
        reads  = n;
        writes = n;
        eab    = 1'b0;
        if (ab_phase >= 0 && ab_phase < 2 * n) begin
            if (ab_phase % 2 == 0) begin
                reads  = ab_phase / 2 + 1;
                writes = ab_phase / 2;
                eab    = 1'b1;
            end else if (ab_phase / 2 != n - 1) begin
                reads  = ab_phase / 2 + 1;
                writes = ab_phase / 2 + 1;
                eab    = 1'b1;
            end
        end
        for (int i = 0; i < reads; i++) begin
            logic [31:0] ra;
            logic [31:0] wa;
            logic [31:0] word;
            ra = sa + 32'(4 * i);
            wa = da + 32'(4 * i);
            exp_bus.push_back('{1'b0, ra, 32'd0});
            if (i < writes) begin
                word    = mdl_rd(ra);
                mdl[wa] = word;
                exp_bus.push_back('{1'b1, wa, word});
            end
        end
        exp_done.push_back('{writes, eab});

        @(posedge clk); #1;
        wait_n   = w;
        acks0    = acks;
        src_addr = s;
        dst_addr = d;
        len      = LEN_W'(n);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = 1;

        if (ab_phase >= 0 && ab_phase < 2 * n) begin
            got = 1'b0;
            for (int k = 0; k < 3000 && !got; k++) begin
                @(negedge clk); #1;
                lat++;
                if (acks - acks0 == ab_phase && bus.dma_stb_o && !bus.dma_ack_i) got = 1'b1;
            end
            if (!got) begin
                tests++;
                fails++;
                $display("FAIL abort_window: got timeout expected phase %0d", ab_phase);
            end
            abort = 1'b1;
            @(negedge clk); #1;
            lat++;
            abort = 1'b0;
        end

        got = done;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk);
            lat++;
            if (n == 0 && bus.dma_stb_o) begin
                tests++;
                fails++;
                $display("FAIL zero_len_stb: got stb=1 expected 0");
            end
            if (done) got = 1'b1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done expected done");
        end else if (w == 0 && ab_phase < 0) begin
            check("latency_bound", 64'(lat <= 4 * n + 2), 64'd1);
        end

        if (poke_done) begin
            #1;
            start = 1'b1;
            len   = LEN_W'(1);
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            check("start_in_done_ignored", {62'd0, busy, bus.dma_stb_o}, 64'd0);
        end
        @(negedge clk);
        @(negedge clk);
        check("idle_after_done", {62'd0, busy, bus.dma_cyc_o}, 64'd0);
    endtask

    task automatic check_dst(input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = d + 32'(4 * i);
            check("dst_word", {32'd0, mem_rd(a)}, {32'd0, mdl_rd(a)});
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_bus", {bus.dma_stb_o, bus.dma_cyc_o, bus.dma_we_o, bus.dma_sel_o, bus.dma_adr_o},
              64'd0);
        check("rst_dat", {32'd0, bus.dma_dat_o}, 64'd0);
        check("rst_status", {busy, done, aborted, xfer_cnt}, 64'd0);

        // spurious ack while idle must not start anything
        @(posedge clk); #1;
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        @(negedge clk);
        check("idle_ack_ignored", {busy, bus.dma_stb_o, xfer_cnt}, 64'd0);

        run(32'h3800_0000, 32'h3800_0100, 3, 0, -1, 1'b0);
        check_dst(32'h3800_0100, 3);
        run(32'h3800_0000, 32'h3800_0200, 0, 0, -1, 1'b0);
        run(32'h3800_0000, 32'h3800_0300, 3, 5, -1, 1'b0);
        check_dst(32'h3800_0300, 3);
        run(32'h3900_0000, 32'h3900_1000, 8, 0, 4, 1'b0);
        run(32'hFFFF_FFFE, 32'h0000_1000, 2, 0, -1, 1'b1);
        run(32'h3A00_0000, 32'h3A00_0100, 2, 1, 3, 1'b0);

        // reset in the middle of a write cycle
        begin
            bit got;
            run_reset_mid_wr(got);
        end
        run(32'h3B00_0004, 32'h3B00_0104, 1, 0, -1, 1'b0);

        for (int it = 0; it < 25; it++) begin
            int n;
            int ab;
            n  = $urandom_range(0, 5);
            ab = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, 2 * n - 1) : -1;
            run($urandom, $urandom, n, $urandom_range(0, 3), ab, 1'(it % 4 == 0));
        end

        check("bus_queue_drained",  64'(exp_bus.size()),  64'd0);
        check("done_queue_drained", 64'(exp_done.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    task automatic run_reset_mid_wr(output bit got);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            exp_bus.push_back('{1'b0, 32'h3C00_0000 + 32'(4 * i), 32'd0});
            exp_bus.push_back('{1'b1, 32'h3C00_0100 + 32'(4 * i), init_word(32'h3C00_0000 + 32'(4 * i))});
        end
        wait_n   = 2;
        src_addr = 32'h3C00_0000;
        dst_addr = 32'h3C00_0100;
        len      = LEN_W'(3);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got   = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk); #1;
            if (bus.dma_stb_o && bus.dma_we_o && !bus.dma_ack_i) got = 1'b1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL reset_wr_window: got timeout expected write phase");
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_bus.delete();
        exp_done.delete();
        mdl = mem;
        @(negedge clk);
        check("rst_mid_wr", {bus.dma_cyc_o, bus.dma_stb_o, busy, done, xfer_cnt}, 64'd0);
        check("rst_mid_wr_adr", {32'd0, bus.dma_adr_o}, 64'd0);
        repeat (4) @(negedge clk);
        check("rst_no_late_ack", {bus.dma_stb_o, busy}, 64'd0);
    endtask

endmodule

// File: doc/wb_dma_master.md
WB_DMA_MASTER -- requirements
Module: wb_dma_master

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of the transfer word count.
REQ-002 SHALL have port wb_clk_i  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a copy; honoured only in IDLE.
REQ-005 SHALL have port abort  input  1  request to stop after the current bus cycle.
REQ-006 SHALL have port src_addr  input  32  source byte address; bits [1:0] ignored and treated as 0.
REQ-007 SHALL have port dst_addr  input  32  destination byte address; bits [1:0] ignored and treated as 0.
REQ-008 SHALL have port len  input  LEN_W  number of 32-bit words to copy.
REQ-009 SHALL have ports dma_stb_o, dma_cyc_o, dma_we_o  output  1 each  Wishbone master strobe, cycle and write enable toward the CPU/DMA arbiter.
REQ-010 SHALL have port dma_sel_o  output  4  byte selects.
REQ-011 SHALL have port dma_adr_o  output  32  bus address.
REQ-012 SHALL have port dma_dat_o  output  32  write data.
REQ-013 SHALL have port dma_ack_i  input  1  slave acknowledge routed back by the arbiter.
REQ-014 SHALL have port dma_dat_i  input  32  read data from the shared slave.
REQ-015 SHALL have ports busy  output  1, done  output  1 (one-cycle pulse), aborted  output  1 (sticky until next start), xfer_cnt  output  LEN_W (words completed).

Function
REQ-016 SHALL implement states IDLE, RD, WR, DONE; all outputs driven from registers.
REQ-017 IDLE: stb=cyc=we=0, busy=0; on start=1, SHALL latch src/dst (low 2 bits cleared) and len, clear xfer_cnt and aborted, and go to RD next cycle if len!=0, else to DONE.
REQ-018 RD: SHALL drive cyc=stb=1, we=0, sel=4'hF, adr=current source; held stable until dma_ack_i=1.
REQ-019 RD on ack: SHALL capture dma_dat_i into the data buffer and enter WR next cycle; cyc/stb deasserted for one cycle between read and write is permitted but not required.
REQ-020 WR: SHALL drive cyc=stb=1, we=1, sel=4'hF, adr=current destination, dat=buffer; held stable until ack.
REQ-021 WR on ack: SHALL add 4 to source and destination addresses (modulo 2^32 wrap), increment xfer_cnt, and go to DONE when xfer_cnt reaches len, else to RD.
REQ-022 dma_ack_i SHALL be ignored in IDLE and DONE and whenever stb=0.
REQ-023 abort SHALL be latched when asserted in RD or WR; the in-flight cycle completes normally, then on that ack the block enters DONE with aborted=1; a RD aborted this way performs no write.
REQ-024 abort and the final WR ack in the same cycle SHALL complete normally with aborted=0.
REQ-025 DONE: SHALL deassert cyc/stb, pulse done=1 for exactly one cycle, return to IDLE next cycle.
REQ-026 start outside IDLE SHALL be ignored; start in the same cycle as DONE SHALL be ignored.
REQ-027 busy SHALL be 1 in RD, WR and DONE.
REQ-028 Latency: len=N, zero-wait-state slave (ack one cycle after stb) SHALL finish in at most 4N+2 cycles from start to done.

Reset
REQ-029 On wb_rst_i=1 at a clock edge, SHALL enter IDLE with all outputs 0 (stb, cyc, we, sel, adr, dat, busy, done, aborted, xfer_cnt) on the following cycle, including mid-transfer; no pending ack is honoured afterwards.

Verification
REQ-030 Copy: src=0x3800_0000, dst=0x3800_0100, len=3, memory model ack after 1 cycle -> 3 reads then 3 writes interleaved, addresses +4 each, dst words equal src words, done pulse once, xfer_cnt=3.
REQ-031 Zero length: start with len=0 -> no stb asserted, done pulse within 2 cycles, xfer_cnt=0.
REQ-032 Wait states: slave inserts 5-cycle ack delay -> adr/dat/we stable throughout each stalled cycle, result identical to REQ-030.
REQ-033 Abort: len=8, abort pulsed during 3rd RD -> 3rd read completes, no 3rd write, aborted=1, xfer_cnt=2, done pulses.
REQ-034 Wrap and alignment: src=0xFFFF_FFFE, len=2 -> first read adr 0xFFFF_FFFC, second 0x0000_0000.
REQ-035 Reset mid-WR with stb high -> next cycle cyc=stb=0, busy=0; subsequent start with len=1 runs normally.
